ps2_key_source: RTL and testbench
=================================

# ps2_key_source

Decodes a raw PS/2 keyboard serial stream (device clock + data lines) into the 11-bit `ps2_key` event word consumed by the core's keyboard handlers. The format is bit 10 toggle-on-event, bit 9 pressed, bit 8 extended, bits 7:0 scancode. It is the producer end of that interface. It lets a core take a physical PS/2 keyboard on the user port, or in a standalone build, in place of the `ps2_key` output of `hps_io`. Downstream logic detects a new event by a change of bit 10 and is unchanged.

## Interface
- `CLK_FILTER`, default 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes level.
- `TIMEOUT`, default 12000: `clk_sys` cycles (1 ms at 12 MHz) allowed between filtered falling edges inside a frame.
- `clk_sys`  in  1  system clock; all logic is in this domain.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk_sys`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk_sys`.
- `ps2_key`  out  11  event word, {toggle, pressed, extended, code[7:0]}.
- `frame_err`  out  1  one-cycle pulse on a discarded frame.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through 2 flip-flops.
  - The filtered clock takes the synchronized level only after `CLK_FILTER` consecutive equal samples.
  - `fall` is a registered one-cycle strobe on each filtered 1→0 transition.
  - Data is sampled from the synchronized `ps2_data` on the `fall` cycle.
- **Frame FSM** (frame is 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1)
  - IDLE: on `fall` with data=0, go to DATA and set bit count to 0. On `fall` with data=1, ignore the edge and stay in IDLE, with no error.
  - DATA: on each `fall`, shift the data bit into `sr[7:0]` (LSB first). After 8 bits, go to PARITY.
  - PARITY: on `fall`, check ^{sr,bit}==1. Go to STOP.
  - STOP: on `fall`, if stop=1 and parity was OK, raise `byte_valid` and return to IDLE. Otherwise pulse `frame_err`, clear the prefix flags, and return to IDLE.
  - Watchdog: counts while the FSM is not in IDLE and resets on each `fall`. On reaching `TIMEOUT`, return to IDLE, pulse `frame_err`, and clear the prefix flags.
- **Byte interpretation** (on `byte_valid`)
  - 0xE0: set `ext`.
  - 0xF0: set `rel`.
  - 0xE1: load `skip`=7. The next 7 valid bytes (the Pause sequence) are discarded with no event.
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFD, 0xFE, 0xFF: discarded, flags unchanged.
  - Any other byte: `ps2_key` <= {~ps2_key[10], ~rel, ext, byte}, then clear `ext` and `rel`.
  - While `skip`≠0, every valid byte only decrements `skip`.
- Prefix flags persist across bytes until they are consumed, a frame error occurs, or reset.

## Timing
- Reset values: `ps2_key`=11'h000, `frame_err`=0, FSM=IDLE, `ext`=`rel`=0, `skip`=0, watchdog=0, filtered clock=1, filter counter=0.
- Reset asserted mid-frame aborts the frame. No event and no `frame_err` are produced.
- Latency:
  - A raw clock edge reaches `fall` 2 (synchronizer) + `CLK_FILTER` + 1 cycles later.
  - `ps2_key` updates exactly 2 cycles after the `fall` that samples the stop bit (cycle 1 `byte_valid`, cycle 2 register).
  - `frame_err` asserts on the cycle after the erroring `fall` or the watchdog expiry. It is high for exactly 1 cycle.
- At most one `ps2_key` change per byte.
- Bit 10 toggles on every emitted event; repeated identical events still toggle.
- Glitches shorter than `CLK_FILTER` cycles produce no `fall`.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN` defined:
  - The block holds `last_make` = {ext, code} and a valid bit.
  - A make whose {ext, code} equals `last_make` is discarded. Its prefix flags are still cleared.
  - A break matching `last_make` clears the valid bit. Any other make replaces `last_make`.
  - Reset clears the valid bit.
- Not defined: every make, typematic repeats included, emits an event.

## Test plan
- Reset, then frame 0x1C (parity 0) → `ps2_key`=11'h61C 2 cycles after the stop `fall`; `frame_err` stays 0.
- Bytes E0, F0, 75 → exactly one event `ps2_key`={~t,0,1,8'h75}. No event after E0 or after F0.
- Frame 0x29 sent with wrong parity → one `frame_err` pulse, bit 10 unchanged. A following good 0x29 emits {~t,1,0,8'h29} with `ext`=`rel`=0.
- Start bit plus 5 data bits, then clock idle for `TIMEOUT`+10 cycles → one `frame_err` pulse. A following full 0x1C frame decodes correctly.
- 3-cycle low glitch on `ps2_clk` (`CLK_FILTER`=8) → no bit shifted, FSM stays in IDLE. E1 14 77 E1 F0 14 F0 77 → no events. A subsequent 0x1C emits an event.
- Bytes 29, 29, 29, F0 29 → with `PS2_TYPEMATIC_FILTER_EN` 2 toggles (make, break). Without it, 4 toggles.

Source files
------------

// File: rtl/ps2_key_source.sv
// ps2_key_source: decodes a raw PS/2 keyboard stream into the 11-bit {toggle, pressed, extended, code} ps2_key event word
// Ports: clk_sys/reset (sync, active-high); ps2_clk/ps2_data raw async PS/2 lines;
//        ps2_key event word (bit 10 toggles per event); frame_err one-cycle pulse on a discarded frame.
// Params: CLK_FILTER stable samples before the filtered clock moves; TIMEOUT clk_sys cycles allowed between bits.
// Macro: PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of the last held key.
module ps2_key_source #(
  parameter int CLK_FILTER = 8,
  parameter int TIMEOUT = 12000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int FW = $clog2(CLK_FILTER + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [1:0] clk_sync, dat_sync;
  logic filt, filt_q, fall;
  logic [FW-1:0] fcnt;
  state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  logic par_ok, byte_valid, ext, rel, ignore, consume, dup;
  logic [WW-1:0] wd;
  logic [2:0] skip;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt <= 1'b1;
      filt_q <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      filt_q <= filt;
      fall <= filt_q & ~filt;
      if (clk_sync[1] == filt) fcnt <= '0;
      else if (fcnt == FW'(CLK_FILTER - 1)) begin
        filt <= clk_sync[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      sr <= '0;
      par_ok <= 1'b0;
      wd <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      wd <= (state == IDLE || fall) ? '0 : wd + 1'b1;
      if (state != IDLE && !fall && wd == WW'(TIMEOUT - 1)) begin
        state <= IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_sync[1]) state <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            sr <= {dat_sync[1], sr[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= ^{sr, dat_sync[1]};
            state <= STOP;
          end
          default: begin
            byte_valid <= dat_sync[1] & par_ok;
            frame_err <= ~(dat_sync[1] & par_ok);
            state <= IDLE;
          end
        endcase
      end
    end
  end
  always_comb begin
    ignore = sr inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hE0, 8'hF0, 8'hE1};
    consume = byte_valid && skip == 3'd0 && !ignore;
  end
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] last_make;
  logic lm_valid, match;
  always_comb begin
    match = lm_valid && last_make == {ext, sr};
    dup = !rel && match;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      last_make <= '0;
      lm_valid <= 1'b0;
    end else if (consume && !rel) begin
      last_make <= {ext, sr};
      lm_valid <= 1'b1;
    end else if (consume && match) lm_valid <= 1'b0;
  end
`else
  always_comb dup = 1'b0;
`endif
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ps2_key <= '0;
      ext <= 1'b0;
      rel <= 1'b0;
      skip <= '0;
    end else if (frame_err) begin
      ext <= 1'b0;
      rel <= 1'b0;
    end else if (byte_valid) begin
      if (skip != 3'd0) skip <= skip - 3'd1;
      else if (sr == 8'hE0) ext <= 1'b1;
      else if (sr == 8'hF0) rel <= 1'b1;
      else if (sr == 8'hE1) skip <= 3'd7;
      else if (consume) begin
        ps2_key <= dup ? ps2_key : {~ps2_key[10], ~rel, ext, sr};
        ext <= 1'b0;
        rel <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_source.sv
// tb_ps2_key_source: table, hand-written and randomized checks of ps2_key_source
module tb_ps2_key_source;
  localparam int CF = 8, TMO = 400, HALF = 16;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam int TYPE_EXP = 2;
`else
  localparam int TYPE_EXP = 4;
`endif
  typedef struct {
    logic [7:0] b;
    bit bp;
    bit bs;
    logic [10:0] key;
    int errs;
    int ev;
  } vec_t;
  logic clk_sys = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic frame_err;
  ps2_key_source #(.CLK_FILTER(CF), .TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_key(ps2_key), .frame_err(frame_err)
  );
  always #5 clk_sys = ~clk_sys;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;
  int n_vec = 0, n_bad = 0;
  int key_changes = 0, err_cnt = 0, long_err = 0, last_key_cyc = 0, last_err_cyc = 0, stop_cyc = 0;
  logic [10:0] prev_key = '0;
  logic prev_err = 1'b0;
  always @(negedge clk_sys) begin
    if (ps2_key !== prev_key) begin
      key_changes++;
      last_key_cyc = cyc;
    end
    if (frame_err === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
      if (prev_err) long_err++;
    end
    prev_key = ps2_key;
    prev_err = frame_err === 1'b1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask
  function automatic logic [10:0] frame(input logic [7:0] b, input bit bp, input bit bs);
    return {~bs, (~^b) ^ bp, b, 1'b0};
  endfunction
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      idle(HALF);
      ps2_clk = 1'b0;
      stop_cyc = cyc;
      idle(HALF);
      ps2_clk = 1'b1;
    end
    idle(HALF);
    ps2_data = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input bit bp, input bit bs);
    send_bits(frame(b, bp, bs), 11);
    idle(4);
  endtask
  function automatic vec_t mk(input logic [7:0] b, input bit bp, input bit bs, input logic [10:0] key, input int errs, input int ev);
    vec_t v;
    v.b = b; v.bp = bp; v.bs = bs; v.key = key; v.errs = errs; v.ev = ev;
    return v;
  endfunction
  logic [10:0] m_key;
  bit m_ext, m_rel, m_lv;
  int m_skip;
  logic [8:0] m_last;
  task automatic m_byte(input logic [7:0] b);
    bit drop;
    drop = 1'b0;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else if (b == 8'hE1) m_skip = 7;
    else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (!m_rel) begin
        drop = m_lv && m_last == {m_ext, b};
        m_last = {m_ext, b};
        m_lv = 1'b1;
      end else if (m_lv && m_last == {m_ext, b}) m_lv = 1'b0;
`endif
      if (!drop) m_key = {~m_key[10], ~m_rel, m_ext, b};
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask
  vec_t tbl[$];
  logic [7:0] ign [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  logic [7:0] pause [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  initial begin
    int k0, e0, r;
    logic [7:0] b;
    bit bad, which;
    tbl.push_back(mk(8'h1C, 0, 0, 11'h61C, 0, 1));
    tbl.push_back(mk(8'hE0, 0, 0, 11'h61C, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 0, 11'h61C, 0, 0));
    tbl.push_back(mk(8'h75, 0, 0, 11'h175, 0, 1));
    tbl.push_back(mk(8'h29, 1, 0, 11'h175, 1, 0));
    tbl.push_back(mk(8'h29, 0, 0, 11'h629, 0, 1));
    tbl.push_back(mk(8'hE0, 0, 0, 11'h629, 0, 0));
    tbl.push_back(mk(8'hF0, 0, 0, 11'h629, 0, 0));
    tbl.push_back(mk(8'h12, 0, 1, 11'h629, 1, 0));
    tbl.push_back(mk(8'h2A, 0, 0, 11'h22A, 0, 1));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(pause[i], 0, 0, 11'h22A, 0, 0));
    tbl.push_back(mk(8'h1C, 0, 0, 11'h61C, 0, 1));
    tbl.push_back(mk(8'hAA, 0, 0, 11'h61C, 0, 0));
    tbl.push_back(mk(8'hFA, 0, 0, 11'h61C, 0, 0));
    tbl.push_back(mk(8'hE0, 0, 0, 11'h61C, 0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 11'h61C, 0, 0));
    tbl.push_back(mk(8'h6B, 0, 0, 11'h36B, 0, 1));
    idle(4);
    chk("reset_key", ps2_key, 11'h000);
    chk("reset_err", frame_err, 1'b0);
    reset = 1'b0;
    idle(10);
    for (int i = 0; i < tbl.size(); i++) begin
      k0 = key_changes;
      e0 = err_cnt;
      send(tbl[i].b, tbl[i].bp, tbl[i].bs);
      chk($sformatf("tbl%0d_key", i), ps2_key, tbl[i].key);
      chk($sformatf("tbl%0d_err", i), err_cnt - e0, tbl[i].errs);
      chk($sformatf("tbl%0d_events", i), key_changes - k0, tbl[i].ev);
      if (tbl[i].ev != 0) chk($sformatf("tbl%0d_key_latency", i), last_key_cyc - stop_cyc, CF + 5);
      if (tbl[i].errs != 0) chk($sformatf("tbl%0d_err_latency", i), last_err_cyc - stop_cyc, CF + 4);
    end
    k0 = key_changes;
    send(8'h29, 0, 0);
    send(8'h29, 0, 0);
    send(8'h29, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h29, 0, 0);
    chk("typematic_toggles", key_changes - k0, TYPE_EXP);
    chk("typematic_key", ps2_key, 11'h029);
    k0 = key_changes;
    e0 = err_cnt;
    send_bits(frame(8'h00, 0, 0), 6);
    idle(TMO + 10);
    chk("timeout_err", err_cnt - e0, 1);
    chk("timeout_events", key_changes - k0, 0);
    send(8'h1C, 0, 0);
    chk("after_timeout_key", ps2_key, 11'h61C);
    chk("after_timeout_err", err_cnt - e0, 1);
    k0 = key_changes;
    e0 = err_cnt;
    ps2_clk = 1'b0;
    idle(3);
    ps2_clk = 1'b1;
    idle(40);
    chk("glitch_err", err_cnt - e0, 0);
    chk("glitch_events", key_changes - k0, 0);
    send(8'h2C, 0, 0);
    chk("after_glitch_key", ps2_key, 11'h22C);
    chk("after_glitch_err", err_cnt - e0, 0);
    e0 = err_cnt;
    send_bits(frame(8'h5A, 0, 0), 4);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(20);
    chk("midreset_key", ps2_key, 11'h000);
    chk("midreset_err", err_cnt - e0, 0);
    send(8'h1C, 0, 0);
    chk("after_midreset_key", ps2_key, 11'h61C);
    chk("after_midreset_err", err_cnt - e0, 0);
    m_key = 11'h61C;
    m_ext = 1'b0;
    m_rel = 1'b0;
    m_skip = 0;
    m_last = 9'h01C;
    m_lv = 1'b1;
    for (int i = 0; i < 48; i++) begin
      r = $urandom_range(0, 15);
      b = r < 2 ? 8'hE0 : r < 4 ? 8'hF0 : r == 4 ? 8'hE1 : r == 5 ? ign[$urandom_range(0, 7)] : 8'($urandom_range(1, 131));
      bad = $urandom_range(0, 7) == 0;
      which = 1'($urandom_range(0, 1));
      e0 = err_cnt;
      send(b, bad && !which, bad && which);
      if (bad) begin
        m_ext = 1'b0;
        m_rel = 1'b0;
      end else m_byte(b);
      chk($sformatf("rnd%0d_key(byte %0h)", i, b), ps2_key, m_key);
      chk($sformatf("rnd%0d_err", i), err_cnt - e0, 32'(bad));
    end
    chk("err_pulse_width", long_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
